// File: rtl/cmp_seq_unit.sv
// cmp_seq_unit: multi-cycle slice-serial comparator (SLT/SLTU/EQ/NE) with early exit on the first differing slice
module cmp_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0] op_q;
  logic res_q;
  logic [SLICE-1:0] top, sa, sb;
  logic accept, diff, lt, last, dec;
  always_comb begin
    top = '0;
    top[SLICE-1] = op_q == 2'b00 && idx == IW'(NSLICE - 1);
    sa = SLICE'(a_q >> (idx * SLICE)) ^ top;
    sb = SLICE'(b_q >> (idx * SLICE)) ^ top;
    diff = sa != sb;
    lt = sa < sb;
    last = diff || idx == '0;
    dec = op_q[1] ? (diff ^ ~op_q[0]) : lt;
    accept = state != RUN && start;
    state_n = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= IW'(NSLICE - 1);
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        op_q <= op;
        idx <= IW'(NSLICE - 1);
      end else if (state == RUN) begin
        if (last) res_q <= dec;
        else idx <= idx - IW'(1);
      end
    end
  end
  assign busy = state == RUN;
  assign done = state == DONE;
  assign result = WIDTH'(res_q);
endmodule

// File: tb/tb_cmp_seq_unit.sv
// tb_cmp_seq_unit: randomized and directed checks of cmp_seq_unit against a slice-level arithmetic model
module tb_cmp_seq_unit;
  localparam logic [1:0] SLT = 2'b00, SLTU = 2'b01, EQ = 2'b10, NE = 2'b11;
  logic clk = 1'b0, reset_n = 1'b0;
  logic s0 = 1'b0, s1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [31:0] a0 = '0, b0 = '0, res0;
  logic [15:0] a1 = '0, b1 = '0, res1;
  logic busy0, done0, busy1, done1;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  cmp_seq_unit dut0 (.clk(clk), .reset_n(reset_n), .start(s0), .op(op0), .a(a0), .b(b0),
                     .busy(busy0), .done(done0), .result(res0));
  cmp_seq_unit #(.WIDTH(16), .SLICE(4)) dut1 (.clk(clk), .reset_n(reset_n), .start(s1), .op(op1),
                     .a(a1), .b(b1), .busy(busy1), .done(done1), .result(res1));

  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                input int w, input int s, output int k, output logic r);
    longint ux, uy, sx, sy;
    int ns;
    bit found;
    ns = w / s;
    ux = longint'(x) & ((64'sd1 <<< w) - 1);
    uy = longint'(y) & ((64'sd1 <<< w) - 1);
    sx = ux[w-1] ? ux - (64'sd1 <<< w) : ux;
    sy = uy[w-1] ? uy - (64'sd1 <<< w) : uy;
    k = ns;
    found = 0;
    for (int i = ns - 1; i >= 0; i--)
      if (!found && ((ux >> (i * s)) % (64'sd1 <<< s)) != ((uy >> (i * s)) % (64'sd1 <<< s))) begin
        k = ns - i;
        found = 1;
      end
    r = o == SLT ? (sx < sy) : o == SLTU ? (ux < uy) : o == EQ ? (ux == uy) : (ux != uy);
  endfunction

  // Drives one request at the current negedge, returns at the negedge of the DONE cycle.
  task automatic issue(input bit sel, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic r, output logic r_run, output bit first_busy,
                       output bit overlap);
    int cyc;
    if (!sel) begin s0 = 1; op0 = o; a0 = x; b0 = y; end
    else begin s1 = 1; op1 = o; a1 = x[15:0]; b1 = y[15:0]; end
    @(negedge clk);
    s0 = 0; s1 = 0;
    op0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
    op1 = 2'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    first_busy = sel ? busy1 : busy0;
    r_run = sel ? res1[0] : res0[0];
    lat = 0; cyc = 0; overlap = 0;
    while (!(sel ? done1 : done0) && cyc < 12) begin
      if (sel ? busy1 : busy0) lat++;
      cyc++;
      @(negedge clk);
    end
    overlap = sel ? (busy1 && done1) : (busy0 && done0);
    if (!(sel ? done1 : done0)) lat = -1;
    r = sel ? res1[0] : res0[0];
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({busy0, done0, res0, busy1, done1, res1} !== '0) begin
      n_err++;
      $display("FAIL reset: got busy0=%b done0=%b res0=%h busy1=%b done1=%b res1=%h, want all 0",
               busy0, done0, res0, busy1, done1, res1);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0] ops[4] = '{SLT, SLTU, EQ, NE};
    logic [31:0] xs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    logic [31:0] ys[4] = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'h1234_5679};
    int ks[4] = '{1, 1, 4, 4};
    logic rs[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int lat;
    logic r, rr;
    bit fb, ov;
    for (int i = 0; i < 4; i++) begin
      issue(0, ops[i], xs[i], ys[i], lat, r, rr, fb, ov);
      n_vec++;
      if (lat !== ks[i] || r !== rs[i] || ov || res0[31:1] !== '0) begin
        n_err++;
        $display("FAIL directed[%0d]: got k=%0d result=%h overlap=%b, want k=%0d result=%0d overlap=0",
                 i, lat, res0, ov, ks[i], rs[i]);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (res0 !== 32'h1 || busy0 || done0) begin
      n_err++;
      $display("FAIL hold: got result=%h busy=%b done=%b, want result=1 busy=0 done=0", res0, busy0, done0);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic r, rr;
    bit fb, ov;
    issue(0, SLT, 32'h8000_0000, 32'h8000_0000, lat, r, rr, fb, ov);
    n_vec++;
    if (lat !== 4 || r !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_first: got k=%0d result=%b, want k=4 result=0", lat, r);
    end
    issue(0, SLTU, 32'h0, 32'h1, lat, r, rr, fb, ov);
    n_vec++;
    if (!fb || lat !== 4 || r !== 1'b1 || rr !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_second: got busy_after_accept=%b k=%0d result=%b result_in_run=%b, want 1 4 1 0",
               fb, lat, r, rr);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int cyc, lat;
    s0 = 1; op0 = SLTU; a0 = 32'h5; b0 = 32'h5;
    @(negedge clk);
    op0 = EQ; a0 = 32'h7; b0 = 32'h7;
    @(negedge clk);
    @(negedge clk);
    s0 = 0;
    lat = 2; cyc = 0;
    while (!done0 && cyc < 12) begin
      if (busy0) lat++;
      cyc++;
      @(negedge clk);
    end
    n_vec++;
    if (!done0 || lat !== 4 || res0 !== 32'h0) begin
      n_err++;
      $display("FAIL ignore_start: got done=%b k=%0d result=%h, want done=1 k=4 result=0", done0, lat, res0);
    end
    @(negedge clk);
    n_vec++;
    if (busy0 || done0) begin
      n_err++;
      $display("FAIL ignore_start_idle: got busy=%b done=%b, want 0 0", busy0, done0);
    end
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    s0 = 1; op0 = EQ; a0 = 32'hABCD_0000; b0 = 32'hABCD_0000;
    @(negedge clk);
    s0 = 0;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    n_vec++;
    if (busy0 || done0 || res0 !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got busy=%b done=%b result=%h, want 0 0 0", busy0, done0, res0);
    end
    @(negedge clk);
    reset_n = 1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1;
    end
    n_vec++;
    if (seen || res0 !== 32'h0) begin
      n_err++;
      $display("FAIL reset_discard: got activity=%b result=%h, want activity=0 result=0", seen, res0);
    end
  endtask

  task automatic test_small();
    int lat;
    logic r, rr;
    bit fb, ov;
    issue(1, SLT, 32'h7FFF, 32'h8000, lat, r, rr, fb, ov);
    n_vec++;
    if (lat !== 1 || r !== 1'b0 || res1[15:1] !== '0) begin
      n_err++;
      $display("FAIL small_slt: got k=%0d result=%h, want k=1 result=0", lat, res1);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic prev[2] = '{1'b0, 1'b0};
    int lat, ek, w, s;
    logic r, rr, er;
    bit fb, ov, sel;
    logic [1:0] o;
    logic [31:0] x, y;
    for (int i = 0; i < 80; i++) begin
      sel = 1'($urandom);
      o = 2'($urandom);
      x = $urandom;
      y = $urandom_range(0, 2) == 0 ? x : $urandom_range(0, 1) == 0 ? x ^ (32'h1 << $urandom_range(0, 31)) : $urandom;
      w = sel ? 16 : 32;
      s = sel ? 4 : 8;
      model(o, x, y, w, s, ek, er);
      issue(sel, o, x, y, lat, r, rr, fb, ov);
      n_vec++;
      if (lat !== ek || r !== er || ov || rr !== prev[sel]) begin
        n_err++;
        $display("FAIL random[%0d] dut%0d op=%0d a=%h b=%h: got k=%0d result=%b overlap=%b run_result=%b, want k=%0d result=%b overlap=0 run_result=%b",
                 i, sel, o, x, y, lat, r, ov, rr, ek, er, prev[sel]);
      end
      prev[sel] = er;
      if ($urandom_range(0, 1) == 0) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid_run();
    test_small();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
